// File: rtl/data_mem_controller_pkg.sv
// Shared encodings for the MEM-stage data memory controller: access sizes,
// FSM states and the access legality check.
package data_mem_controller_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STORE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } state_e;

    // An access is rejected when misaligned for its size, of illegal size,
    // or when its byte address lies beyond the end of DataMemory.
    function automatic logic access_error(input size_e size,
                                          input logic [31:0] addr,
                                          input logic [31:0] mem_bytes);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_HALF:    bad = addr[0];
            SIZE_WORD:    bad = (addr[1:0] != 2'b00);
            SIZE_ILLEGAL: bad = 1'b1;
            default:      bad = 1'b0;
        endcase
        if (addr >= mem_bytes) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/data_mem_controller_lane_unit.sv
// Little-endian lane handling: extracts and extends the addressed byte/half
// of a memory word for loads, and splices store data into a word for RMW.
module data_mem_controller_lane_unit
    import data_mem_controller_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rd_word_i,
    output logic [31:0] load_data_o,
    input  logic [31:0] merge_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] merged_o
);

    logic [3:0][7:0]  rd_bytes;
    logic [1:0][15:0] rd_halves;
    logic [7:0]       byte_lane;
    logic [15:0]      half_lane;
    logic             is_byte;
    logic             is_half;
    logic [31:0]      wdata_rep;
    logic [3:0]       lane_en;

    assign rd_bytes  = rd_word_i;
    assign rd_halves = rd_word_i;
    assign byte_lane = rd_bytes[addr_lo_i];
    assign half_lane = rd_halves[addr_lo_i[1]];
    assign is_byte   = (size_e'(size_i) == SIZE_BYTE);
    assign is_half   = (size_e'(size_i) == SIZE_HALF);

    always_comb begin
        load_data_o = rd_word_i;
        wdata_rep   = wdata_i;
        if (is_byte) begin
            load_data_o = {{24{signed_i & byte_lane[7]}}, byte_lane};
            wdata_rep   = {4{wdata_i[7:0]}};
        end else if (is_half) begin
            load_data_o = {{16{signed_i & half_lane[15]}}, half_lane};
            wdata_rep   = {2{wdata_i[15:0]}};
        end
    end

    // Store data is replicated across all lanes; the per-byte enable picks
    // which lanes take it and which keep the word read back from memory.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_en[gi] = is_byte ? (addr_lo_i == 2'(gi)) :
                                 is_half ? (addr_lo_i[1] == 1'(gi / 2)) : 1'b1;
            assign merged_o[8*gi+7 -: 8] = lane_en[gi] ? wdata_rep[8*gi+7 -: 8]
                                                       : merge_word_i[8*gi+7 -: 8];
        end
    endgenerate

endmodule

// File: rtl/data_mem_controller.sv
// MEM-stage controller that sequences loads, word stores and read-modify-write
// sub-word stores into a word-wide DataMemory with a combinational read port.
module data_mem_controller
    import data_mem_controller_pkg::*;
#(
    parameter int MEM_BYTES  = 4096,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  req_write_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_signed_i,
    input  logic [31:0]           req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [31:0]           mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_write_data_o,
    output logic                  mem_write_o,
    output logic                  mem_read_o,
    input  logic [DATA_WIDTH-1:0] mem_read_data_i
);

    state_e                state_q;
    state_e                state_d;
    logic                  write_q;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic [31:0]           addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] merge_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  req_err;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merged_word;

    assign req_err = access_error(size_e'(req_size_i), req_addr_i, 32'(MEM_BYTES));

    data_mem_controller_lane_unit u_lane (
        .size_i       (size_q),
        .signed_i     (signed_q),
        .addr_lo_i    (addr_q[1:0]),
        .rd_word_i    (mem_read_data_i),
        .load_data_o  (load_data),
        .merge_word_i (merge_q),
        .wdata_i      (wdata_q),
        .merged_o     (merged_word)
    );

    always_comb begin
        state_d          = state_q;
        mem_read_o       = 1'b0;
        mem_write_o      = 1'b0;
        mem_write_data_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else if (!req_write_i) begin
                        state_d = ST_LOAD;
                    end else if (size_e'(req_size_i) == SIZE_WORD) begin
                        state_d = ST_STORE;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD: begin
                mem_read_o = 1'b1;
                state_d    = ST_RESP;
            end
            ST_STORE: begin
                mem_write_o      = 1'b1;
                mem_write_data_o = wdata_q;
                state_d          = ST_RESP;
            end
            ST_RMW_RD: begin
                mem_read_o = 1'b1;
                state_d    = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                mem_write_o      = 1'b1;
                mem_write_data_o = merged_word;
                state_d          = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_RESP);
    assign err_o         = err_q;
    assign rdata_o       = rdata_q;
    assign mem_address_o = {addr_q[31:2], 2'b00};

    // Err and RData only change on the edge that enters RESP, so they stay
    // stable from one Done pulse to the next.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        write_q  <= req_write_i;
                        size_q   <= req_size_i;
                        signed_q <= req_signed_i;
                        addr_q   <= req_addr_i;
                        wdata_q  <= req_wdata_i;
                        if (req_err) begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end
                    end
                end
                ST_LOAD: begin
                    rdata_q <= load_data;
                    err_q   <= 1'b0;
                end
                ST_STORE, ST_RMW_WR: begin
                    err_q <= 1'b0;
                end
                ST_RMW_RD: begin
                    merge_q <= mem_read_data_i;
                end
                default: begin
                end
            endcase
        end
    end

    logic unused_write;
    assign unused_write = write_q;

endmodule

// File: tb/tb_data_mem_controller.sv
// Self-checking bench for data_mem_controller: a bench-owned DataMemory model,
// directed scenarios and randomized traffic against a byte-arithmetic reference.
module tb_data_mem_controller;

    localparam int MEM_BYTES = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data;

    logic [31:0] dmem    [0:1023];
    logic [31:0] ref_mem [0:1023];

    int tests_run    = 0;
    int tests_failed = 0;

    int          lat;
    int          rd_n;
    int          wr_n;
    int          rd_cyc;
    int          wr_cyc;
    logic [31:0] wr_addr;
    logic [31:0] res_rdata;
    logic        res_err;

    data_mem_controller #(.MEM_BYTES(MEM_BYTES), .DATA_WIDTH(32)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .req_i            (req),
        .req_write_i      (req_write),
        .req_size_i       (req_size),
        .req_signed_i     (req_signed),
        .req_addr_i       (req_addr),
        .req_wdata_i      (req_wdata),
        .busy_o           (busy),
        .done_o           (done),
        .err_o            (err),
        .rdata_o          (rdata),
        .mem_address_o    (mem_address),
        .mem_write_data_o (mem_write_data),
        .mem_write_o      (mem_write),
        .mem_read_o       (mem_read),
        .mem_read_data_i  (mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = dmem[mem_address[11:2]];
    always @(posedge clk) begin
        if (mem_write) dmem[mem_address[11:2]] <= mem_write_data;
    end

    // ---------------- reference model ----------------
    function automatic logic ref_err(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd3) return 1'b1;
        if (a >= 32'(MEM_BYTES)) return 1'b1;
        if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
        if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic sg);
        logic [31:0] w;
        logic [31:0] v;
        w = ref_mem[a[11:2]];
        if (sz == 2'd2) return w;
        if (sz == 2'd0) begin
            v = (w >> (8 * int'(a % 4))) & 32'hFF;
            if (sg && v >= 32'h80) v = v - 32'h100;
        end else begin
            v = (w >> (16 * int'((a / 2) % 2))) & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v - 32'h10000;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] old;
        logic [31:0] mask;
        int          sh;
        old = ref_mem[a[11:2]];
        if (sz == 2'd2) begin
            ref_mem[a[11:2]] = wd;
        end else begin
            sh   = (sz == 2'd0) ? 8 * int'(a % 4) : 16 * int'((a / 2) % 2);
            mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
            ref_mem[a[11:2]] = (old & ~mask) | ((wd << sh) & mask);
        end
    endtask

    function automatic int ref_latency(input logic w, input logic [1:0] sz, input logic e);
        if (e) return 1;
        if (!w || sz == 2'd2) return 2;
        return 3;
    endfunction

    // ---------------- driver ----------------
    task automatic do_access(input logic w, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd);
        int  guard;
        bit  timed_out;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req        = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0; rd_n = 0; wr_n = 0; rd_cyc = 0; wr_cyc = 0;
        wr_addr = 32'h0; res_rdata = 32'h0; res_err = 1'b0;
        timed_out = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_read) begin rd_n++; rd_cyc = c; end
            if (mem_write) begin wr_n++; wr_cyc = c; wr_addr = mem_address; end
            if (done) begin
                lat = c; res_rdata = rdata; res_err = err; timed_out = 1'b0;
                break;
            end
        end
        if (timed_out) begin
            tests_run++; tests_failed++;
            $display("[TB] FAIL done_timeout: no Done within 10 cycles for addr=%h", a);
        end
        $display("[TB] txn w=%0d sz=%0d sg=%0d addr=%h wd=%h -> err=%0d rdata=%h lat=%0d",
                 w, sz, sg, a, wd, res_err, res_rdata, lat);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done, err, mem_write, mem_read} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000", {busy, done, err, mem_write, mem_read});
        end
        tests_run++;
        if (rdata !== 32'h0 || mem_address !== 32'h0 || mem_write_data !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: rdata=%h addr=%h wdata=%h expected all 0", rdata, mem_address, mem_write_data);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_release: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_word_store_load;
        do_access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        ref_store(32'h10, 2'd2, 32'hDEADBEEF);
        tests_run++;
        if (wr_n !== 1 || wr_addr !== 32'h10 || rd_n !== 0) begin
            tests_failed++;
            $display("[TB] FAIL sw_mem: wr_n=%0d addr=%h rd_n=%0d expected 1 00000010 0", wr_n, wr_addr, rd_n);
        end
        tests_run++;
        if (lat !== 2) begin
            tests_failed++;
            $display("[TB] FAIL sw_latency: got %0d expected 2", lat);
        end
        tests_run++;
        if (dmem[4] !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("[TB] FAIL sw_word: got %h expected deadbeef", dmem[4]);
        end
        do_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        tests_run++;
        if (res_rdata !== 32'hDEADBEEF || res_err !== 1'b0 || lat !== 2) begin
            tests_failed++;
            $display("[TB] FAIL lw_back: rdata=%h err=%b lat=%0d expected deadbeef 0 2", res_rdata, res_err, lat);
        end
    endtask

    task automatic test_byte_rmw;
        dmem[8] = 32'h11223344; ref_mem[8] = 32'h11223344;
        do_access(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AB);
        ref_store(32'h21, 2'd0, 32'h000000AB);
        tests_run++;
        if (dmem[8] !== 32'h1122AB44 || ref_mem[8] !== 32'h1122AB44) begin
            tests_failed++;
            $display("[TB] FAIL sb_word: got %h expected 1122ab44", dmem[8]);
        end
        tests_run++;
        if (lat !== 3) begin
            tests_failed++;
            $display("[TB] FAIL sb_latency: got %0d expected 3", lat);
        end
        tests_run++;
        if (rd_n !== 1 || wr_n !== 1 || rd_cyc !== 1 || wr_cyc !== 2) begin
            tests_failed++;
            $display("[TB] FAIL sb_sequence: rd_n=%0d@%0d wr_n=%0d@%0d expected 1@1 1@2", rd_n, rd_cyc, wr_n, wr_cyc);
        end
    endtask

    task automatic test_subword_loads;
        logic [1:0]  szs  [4];
        logic        sgs  [4];
        logic [31:0] adrs [4];
        logic [31:0] exps [4];
        szs  = '{2'd0, 2'd0, 2'd1, 2'd1};
        sgs  = '{1'b1, 1'b0, 1'b1, 1'b0};
        adrs = '{32'h30, 32'h30, 32'h32, 32'h32};
        exps = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8070, 32'h00008070};
        dmem[12] = 32'h8070FF80; ref_mem[12] = 32'h8070FF80;
        for (int i = 0; i < 4; i++) begin
            do_access(1'b0, szs[i], sgs[i], adrs[i], 32'h0);
            tests_run++;
            if (res_rdata !== exps[i] || res_err !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL subword_load%0d: rdata=%h err=%b expected %h 0", i, res_rdata, res_err, exps[i]);
            end
        end
    endtask

    task automatic test_errors;
        logic        ws   [4];
        logic [1:0]  szs  [4];
        logic [31:0] adrs [4];
        ws   = '{1'b0, 1'b1, 1'b0, 1'b0};
        szs  = '{2'd2, 2'd1, 2'd2, 2'd3};
        adrs = '{32'h31, 32'h33, 32'h1000, 32'h20};
        for (int i = 0; i < 4; i++) begin
            do_access(ws[i], szs[i], 1'b0, adrs[i], 32'h12345678);
            tests_run++;
            if (res_err !== 1'b1 || res_rdata !== 32'h0 || lat !== 1 || rd_n !== 0 || wr_n !== 0) begin
                tests_failed++;
                $display("[TB] FAIL error%0d: err=%b rdata=%h lat=%0d rd=%0d wr=%0d expected 1 0 1 0 0",
                         i, res_err, res_rdata, lat, rd_n, wr_n);
            end
        end
    endtask

    task automatic test_random;
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic        e;
        int          r;
        for (int n = 0; n < 120; n++) begin
            r  = int'($urandom_range(0, 15));
            sz = (r == 0) ? 2'd3 : 2'(r % 3);
            w  = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            wd = $urandom;
            a  = 32'($urandom_range(0, MEM_BYTES - 1));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a = a & ~32'h1;
                if (sz == 2'd2) a = a & ~32'h3;
            end
            if ($urandom_range(0, 15) == 0) a = a + 32'(MEM_BYTES);
            e = ref_err(a, sz);
            do_access(w, sz, sg, a, wd);
            tests_run++;
            if (res_err !== e || lat !== ref_latency(w, sz, e)) begin
                tests_failed++;
                $display("[TB] FAIL rand_err_lat n=%0d: err=%b lat=%0d expected %b %0d", n, res_err, lat, e, ref_latency(w, sz, e));
            end
            if (e) begin
                tests_run++;
                if (res_rdata !== 32'h0 || rd_n !== 0 || wr_n !== 0) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_err_access n=%0d: rdata=%h rd=%0d wr=%0d expected 0 0 0", n, res_rdata, rd_n, wr_n);
                end
            end else if (!w) begin
                tests_run++;
                if (res_rdata !== ref_load(a, sz, sg)) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_load n=%0d: rdata=%h expected %h", n, res_rdata, ref_load(a, sz, sg));
                end
            end else begin
                ref_store(a, sz, wd);
                tests_run++;
                if (dmem[a[11:2]] !== ref_mem[a[11:2]]) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_store n=%0d: word=%h expected %h", n, dmem[a[11:2]], ref_mem[a[11:2]]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_rmw;
        int guard;
        guard = 0;
        dmem[16] = 32'hCAFEF00D; ref_mem[16] = 32'hCAFEF00D;
        @(negedge clk);
        while (busy && guard < 20) begin @(negedge clk); guard++; end
        req = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h42; req_wdata = 32'h0000005A;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (mem_write !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rmw_wr_reached: mem_write=%b expected 1", mem_write);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (mem_write !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_abort: mem_write=%b busy=%b done=%b expected 0 0 0", mem_write, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] txn reset during RMW_WR of addr=00000042");
        repeat (2) @(negedge clk);
        tests_run++;
        if (dmem[16] !== 32'hCAFEF00D) begin
            tests_failed++;
            $display("[TB] FAIL reset_no_write: word=%h expected cafef00d", dmem[16]);
        end
        do_access(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        tests_run++;
        if (res_rdata !== ref_mem[16] || res_err !== 1'b0 || lat !== 2) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_load: rdata=%h err=%b lat=%0d expected %h 0 2", res_rdata, res_err, lat, ref_mem[16]);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] adrs [3];
        int          done_t [3];
        int          acc;
        int          nd;
        int          idle_n;
        adrs = '{32'h100, 32'h204, 32'h3F8};
        acc = 0; nd = 0; idle_n = 0;
        for (int i = 0; i < 3; i++) begin
            dmem[adrs[i][11:2]] = $urandom;
            ref_mem[adrs[i][11:2]] = dmem[adrs[i][11:2]];
            done_t[i] = 0;
        end
        @(negedge clk);
        for (int cyc = 0; cyc < 40 && nd < 3; cyc++) begin
            if (done) begin
                tests_run++;
                if (rdata !== ref_load(adrs[nd], 2'd2, 1'b0) || busy !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_data%0d: rdata=%h busy=%b expected %h 1", nd, rdata, busy, ref_load(adrs[nd], 2'd2, 1'b0));
                end
                $display("[TB] txn b2b lw addr=%h -> rdata=%h at cycle %0d", adrs[nd], rdata, cyc);
                done_t[nd] = cyc;
                nd++;
            end
            if (!busy) begin
                idle_n++;
                if (acc < 3) begin
                    req = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
                    req_addr = adrs[acc]; req_wdata = 32'h0;
                    acc++;
                end else begin
                    req = 1'b0;
                end
            end
            if (nd < 3) @(negedge clk);
        end
        req = 1'b0;
        tests_run++;
        if (nd !== 3 || done_t[1] - done_t[0] !== 3 || done_t[2] - done_t[1] !== 3 || idle_n !== 3) begin
            tests_failed++;
            $display("[TB] FAIL b2b_timing: dones=%0d gaps=%0d,%0d idle=%0d expected 3 3,3 3",
                     nd, done_t[1] - done_t[0], done_t[2] - done_t[1], idle_n);
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            dmem[i] = $urandom;
            ref_mem[i] = dmem[i];
        end
        test_reset();
        test_word_store_load();
        test_byte_rmw();
        test_subword_loads();
        test_errors();
        test_reset_mid_rmw();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
